// File: rtl/core_pkg.sv
// Shared core definitions: register address width, forwarding-select
// encodings and the hazard sequencer state enum.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

endpackage

// File: rtl/hazard_stage_trk.sv
// Per-stage tracking register. Loads d (or all-zero/invalid on bubble)
// when advance=1, otherwise holds. Ports: clk, rst_n, advance, bubble, d, q.
module hazard_stage_trk #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic bubble,
  input  T     d,
  output T     q
);

  T trk_q, trk_d;

  always_comb begin
    trk_d = trk_q;
    if (advance) begin
      if (bubble) trk_d = '0;
      else        trk_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trk_q <= '0;
    else        trk_q <= trk_d;
  end

  assign q = trk_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use/RAW stalls, redirect flush,
// dmem-wait freeze, EX forwarding selects and a saturating stall counter.
// Ports: id_* decoder fields, ex_redirect, dmem_ready in; stall_pc,
// stall_ifid, flush_ifid, bubble_ex, freeze_back, fwd_a/b_sel, stall_cnt out.
// Build option HAZARD_FWD_EN: forwarding on; otherwise stall on any RAW hit.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  ex_redirect,
  input  logic                  dmem_ready,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_ex,
  output logic                  freeze_back,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  import core_pkg::*;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
  } trk_t;

  function automatic logic hit(input trk_t s,
                               input logic [REG_ADDR_W-1:0] r);
    return s.v & s.regwrite & (|s.rd) & (s.rd == r);
  endfunction

  trk_t id_s, ex_s, mem_s, wb_s;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_pend, freeze, adv, use_hit, need_stall;
  logic unused_wb;

  assign id_s = '{v:        1'b1,
                  rd:       id_rd,
                  rs1:      id_rs1,
                  rs2:      id_rs2,
                  regwrite: id_regwrite,
                  memread:  id_memread,
                  memwrite: id_memwrite};

  assign mem_pend = mem_s.v & (mem_s.memread | mem_s.memwrite);
  assign freeze   = mem_pend & ~dmem_ready;
  assign adv      = ~freeze;

  hazard_stage_trk #(.T(trk_t)) u_ex (
    .clk, .rst_n,
    .advance(adv),
    .bubble (bubble_ex | ~id_valid),
    .d      (id_s),
    .q      (ex_s)
  );

  hazard_stage_trk #(.T(trk_t)) u_mem (
    .clk, .rst_n,
    .advance(adv),
    .bubble (1'b0),
    .d      (ex_s),
    .q      (mem_s)
  );

  hazard_stage_trk #(.T(trk_t)) u_wb (
    .clk, .rst_n,
    .advance(adv),
    .bubble (1'b0),
    .d      (mem_s),
    .q      (wb_s)
  );

  // WB only supplies rd/regwrite for hit detection
  assign unused_wb = ^wb_s;

`ifdef HAZARD_FWD_EN
  assign use_hit = ex_s.memread &
                   (hit(ex_s, id_rs1) | hit(ex_s, id_rs2));

  // MEM checked last so it overrides WB
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (hit(wb_s, ex_s.rs1))  fwd_a_sel = FWD_MEMWB;
    if (hit(mem_s, ex_s.rs1)) fwd_a_sel = FWD_EXMEM;
    if (hit(wb_s, ex_s.rs2))  fwd_b_sel = FWD_MEMWB;
    if (hit(mem_s, ex_s.rs2)) fwd_b_sel = FWD_EXMEM;
  end
`else
  // regfile is not write-through, so a WB producer also blocks
  assign use_hit = hit(ex_s, id_rs1)  | hit(ex_s, id_rs2)  |
                   hit(mem_s, id_rs1) | hit(mem_s, id_rs2) |
                   hit(wb_s, id_rs1)  | hit(wb_s, id_rs2);

  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;
`endif

  assign need_stall = id_valid & use_hit;

  // freeze wins over redirect: EX re-presents it after the wait
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_ex   = 1'b0;
    freeze_back = 1'b0;
    priority case (1'b1)
      freeze: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        freeze_back = 1'b1;
      end
      ex_redirect: begin
        flush_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end
      need_stall: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (freeze)     state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_d = RUN;
      default:                  state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_pc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: pipeline reference model, directed
// scenarios and random stimulus. Honours HAZARD_FWD_EN like the design.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int CW = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_regwrite, id_memread, id_memwrite;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_redirect, dmem_ready;
  logic stall_pc, stall_ifid, flush_ifid, bubble_ex, freeze_back;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
    .freeze_back(freeze_back),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit rw; bit mr; bit mw;
  } ins_t;

  typedef struct {
    bit spc; bit sif; bit fl; bit bub; bit frz;
    int fa; int fb; int cnt; bit wst;
  } exp_t;

  ins_t pipe[3];
  int   m_cnt;
  bit   m_wait;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  ins_t nop = '{default: 0};

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic ins_t mk(int rd, int rs1, int rs2,
                              bit rw, bit mr, bit mw);
    ins_t i;
    i = '{v: 1, rd: rd, rs1: rs1, rs2: rs2, rw: rw, mr: mr, mw: mw};
    return i;
  endfunction

  function automatic bit hits(ins_t s, int r);
    return s.v && s.rw && s.rd != 0 && s.rd == r;
  endfunction

  function automatic int fsel(int r);
    if (hits(pipe[1], r)) return 1;
    if (hits(pipe[2], r)) return 2;
    return 0;
  endfunction

  function automatic exp_t decide();
    exp_t e;
    bit frz, need;
    e = '{default: 0};
    frz = pipe[1].v && (pipe[1].mr || pipe[1].mw) && !dmem_ready;
    need = 0;
    for (int k = 0; k < 3; k++)
      if (!FWD || (k == 0 && pipe[0].mr))
        if (hits(pipe[k], id_rs1) || hits(pipe[k], id_rs2)) need = 1;
    need = need && id_valid;
    if (frz) begin
      e.spc = 1; e.sif = 1; e.frz = 1;
    end else if (ex_redirect) begin
      e.fl = 1; e.bub = 1;
    end else if (need) begin
      e.spc = 1; e.sif = 1; e.bub = 1;
    end
    if (FWD) begin
      e.fa = fsel(pipe[0].rs1);
      e.fb = fsel(pipe[0].rs2);
    end
    e.cnt = m_cnt;
    e.wst = m_wait;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = nop;
    m_cnt = 0;
    m_wait = 0;
  endtask

  task automatic model_step();
    exp_t e;
    e = decide();
    if (!e.frz) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e.bub || !id_valid) pipe[0] = nop;
      else pipe[0] = mk(id_rd, id_rs1, id_rs2,
                        id_regwrite, id_memread, id_memwrite);
    end
    if (e.spc && m_cnt < (1 << CW) - 1) m_cnt++;
    m_wait = e.frz;
  endtask

  task automatic drive(ins_t i, bit redir, bit rdy);
    id_valid    = i.v;
    id_rd       = 5'(i.rd);
    id_rs1      = 5'(i.rs1);
    id_rs2      = 5'(i.rs2);
    id_regwrite = i.rw;
    id_memread  = i.mr;
    id_memwrite = i.mw;
    ex_redirect = redir;
    dmem_ready  = rdy;
  endtask

  task automatic cyc(ins_t i, bit redir, bit rdy);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    drive(i, redir, rdy);
    sb.push_back(decide());
  endtask

  task automatic drop_reset();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    rst_n = 1'b0;
    drive(nop, 0, 1);
    model_reset();
    #1;
    chk("rst_freeze", int'(freeze_back), 0);
    chk("rst_stall", int'(stall_pc), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    sb.push_back(decide());
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(nop, 0, 1);
    sb.push_back(decide());
  endtask

  task automatic reset_seq();
    drop_reset();
    cyc(nop, 0, 1);
    release_reset();
  endtask

  // present i in ID until the DUT stops holding IF/ID
  task automatic issue(ins_t i, output int stalls);
    stalls = 0;
    for (int n = 0; n < 20; n++) begin
      cyc(i, 0, 1);
      @(negedge clk);
      if (stall_ifid !== 1'b1) return;
      stalls++;
    end
    chk("issue_timeout", 1, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_pc", int'(stall_pc), int'(e.spc));
        chk("stall_ifid", int'(stall_ifid), int'(e.sif));
        chk("flush_ifid", int'(flush_ifid), int'(e.fl));
        chk("bubble_ex", int'(bubble_ex), int'(e.bub));
        chk("freeze_back", int'(freeze_back), int'(e.frz));
        chk("fwd_a_sel", int'(fwd_a_sel), e.fa);
        chk("fwd_b_sel", int'(fwd_b_sel), e.fb);
        chk("stall_cnt", int'(stall_cnt), e.cnt);
        chk("state", int'(dut.state_q == MEM_WAIT), int'(e.wst));
      end
    end
  end

  initial begin
    int s, nf;
    bit rw, mr;
    drive(nop, 0, 1);
    model_reset();
    cyc(nop, 0, 1);
    cyc(nop, 0, 1);
    release_reset();

    // 1: add x5,x1,x2 ; sub x6,x5,x3
    issue(mk(5, 1, 2, 1, 0, 0), s);
    issue(mk(6, 5, 3, 1, 0, 0), s);
    chk("s1_stalls", s, FWD ? 0 : 3);
    cyc(nop, 0, 1);
    @(negedge clk);
    chk("s1_fwd_a", int'(fwd_a_sel), FWD ? 1 : 0);

    // 2: lw x7,0(x1) ; add x8,x7,x7
    reset_seq();
    issue(mk(7, 1, 0, 1, 1, 0), s);
    issue(mk(8, 7, 7, 1, 0, 0), s);
    chk("s2_stalls", s, FWD ? 1 : 3);
    cyc(nop, 0, 1);
    @(negedge clk);
    chk("s2_fwd_a", int'(fwd_a_sel), FWD ? 2 : 0);
    chk("s2_fwd_b", int'(fwd_b_sel), FWD ? 2 : 0);
    chk("s2_cnt", int'(stall_cnt), FWD ? 1 : 3);

    // 3: lw stuck in MEM for 3 cycles
    reset_seq();
    issue(mk(7, 1, 0, 1, 1, 0), s);
    cyc(nop, 0, 1);
    nf = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(nop, 0, k == 3);
      @(negedge clk);
      if (freeze_back === 1'b1) nf++;
    end
    chk("s3_freeze_cycles", nf, 3);
    cyc(nop, 0, 1);
    @(negedge clk);
    chk("s3_cnt", int'(stall_cnt), 3);

    // 4: redirect beats load-use
    reset_seq();
    issue(mk(7, 1, 0, 1, 1, 0), s);
    cyc(mk(8, 7, 7, 1, 0, 0), 1, 1);
    @(negedge clk);
    chk("s4_flush", int'(flush_ifid), 1);
    chk("s4_bubble", int'(bubble_ex), 1);
    chk("s4_stall", int'(stall_pc), 0);

    // 5: x0 never hits; then plain RAW on x5
    reset_seq();
    issue(mk(0, 1, 2, 1, 0, 0), s);
    issue(mk(6, 0, 0, 1, 0, 0), s);
    chk("s5_x0_stalls", s, 0);
    cyc(nop, 0, 1);
    @(negedge clk);
    chk("s5_x0_fwd", int'(fwd_a_sel), 0);
    reset_seq();
    issue(mk(5, 1, 2, 1, 0, 0), s);
    issue(mk(6, 5, 0, 1, 0, 0), s);
    chk("s5_raw_stalls", s, FWD ? 0 : 3);

    // 6: reset during MEM_WAIT
    reset_seq();
    issue(mk(7, 1, 0, 1, 1, 0), s);
    cyc(nop, 0, 1);
    cyc(nop, 0, 0);
    cyc(nop, 0, 0);
    drop_reset();
    cyc(nop, 0, 1);
    release_reset();
    issue(mk(8, 7, 7, 1, 0, 0), s);
    chk("s6_no_stale", s, 0);

    // random traffic
    reset_seq();
    for (int n = 0; n < 1500; n++) begin
      ins_t i;
      mr = ($urandom_range(0, 3) == 0);
      rw = mr || ($urandom_range(0, 2) != 0);
      i = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), rw, mr,
             !mr && ($urandom_range(0, 5) == 0));
      i.v = ($urandom_range(0, 9) != 0);
      cyc(i, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
